// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, keeps one instruction-memory request in
// flight at a time and presents a two-slot fetch packet to decode.
// PC source priority is flush, then decode redirect, then sequential.
// Responses that were already in flight when a redirect arrived are dropped.
module fetch_sequencer #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 64,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush_valid,
  input  logic [AW-1:0] flush_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [AW-1:0] inst_pc,
  output logic [1:0]    inst_mask,
  output logic [DW-1:0] inst_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL
  } state_e;

  // One fetch line is 8 bytes; the line index is the PC above bit 3.
  localparam logic [AW-4:0] LINE_ONE = {{(AW-4){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]    inst_mask_q, inst_mask_d;
  logic [DW-1:0] inst_data_q, inst_data_d;

  logic          redir;
  logic [AW-1:0] tgt;
  logic          out_free;
  logic          req;
  logic [AW-4:0] line_next;
  logic [AW-1:0] seq_pc;
  logic [1:0]    slot_mask;

  // Redirect arbitration: a flush overrides a decode redirect.
  assign redir = flush_valid | redirect_valid;
  assign tgt   = flush_valid ? flush_pc : redirect_pc;

  // Output register can take a new packet if empty or drained this cycle.
  assign out_free = !inst_valid_q || !stall;

  // Sequential PC moves to the start of the next line, wrapping at the top.
  assign line_next = pc_q[AW-1:3] + LINE_ONE;
  assign seq_pc    = {line_next, 3'b000};

  // An odd-word PC means the lower slot precedes the target and is invalid.
  assign slot_mask = pc_q[2] ? 2'b10 : 2'b11;

  // Request only when the packet it produces is guaranteed a free output slot.
  always_comb begin
    req = (state_q == S_REQ) && out_free && !redir;
  end

  // Next-state and datapath update for the PC, FSM and fetch packet register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q && stall;
    inst_pc_d    = inst_pc_q;
    inst_mask_d  = inst_mask_q;
    inst_data_d  = inst_data_q;

    // Any redirect invalidates the packet on offer, stalled or not.
    if (redir) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir) begin
          pc_d = tgt;
        end
      end

      S_REQ: begin
        if (redir) begin
          pc_d = tgt;
        end else if (req && imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redir) begin
          pc_d    = tgt;
          // A response arriving with the redirect is stale and retires the
          // outstanding request; otherwise wait for it in KILL.
          state_d = imem_rvalid ? S_REQ : S_KILL;
        end else if (imem_rvalid) begin
          inst_valid_d = 1'b1;
          inst_pc_d    = pc_q;
          inst_mask_d  = slot_mask;
          inst_data_d  = imem_rdata;
          pc_d         = seq_pc;
          state_d      = S_REQ;
        end
      end

      S_KILL: begin
        if (redir) begin
          pc_d = tgt;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_mask_q  <= '0;
      inst_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_mask_q  <= inst_mask_d;
      inst_data_q  <= inst_data_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = {pc_q[AW-1:3], 3'b000};
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst_mask  = inst_mask_q;
  assign inst_data  = inst_data_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch stage: owns the fetch PC, runs one outstanding request at a time to instruction memory, and presents a two-instruction fetch packet to decode.
- Arbitrates PC sources. Priority order: exception flush, then decode redirect (branch/jump), then sequential.
- Drops stale responses that are still in flight when a redirect arrives.
- Sits between the instruction memory port and the decode stage of the dual-issue pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be 4-byte aligned.
- AW, 32, address/PC width.
- DW, 64, fetch packet width (two 32-bit instructions).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  decode cannot accept the fetch packet this cycle.
- flush_valid  in  1  exception/flush redirect request.
- flush_pc  in  AW  flush target.
- redirect_valid  in  1  branch/jump redirect request from decode.
- redirect_pc  in  AW  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  AW  request address, always 8-byte aligned ({pc[31:3],3'b000}).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, one per granted request, latency ≥ 1 cycle.
- imem_rdata  in  DW  response data; [31:0] is the lower word, [63:32] the upper word.
- inst_valid  out  1  fetch packet valid.
- inst_pc  out  AW  PC of the first valid slot.
- inst_mask  out  2  slot valid mask; bit 0 = lower word, bit 1 = upper word.
- inst_data  out  DW  fetch packet.

Behaviour:
- While reset = 0, asynchronously force:
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0, inst_valid = 0, inst_pc = 0, inst_mask = 0, inst_data = 0.
- The memory shares this reset, so no response from before reset is expected.
- The fetch packet is consumed when inst_valid && !stall.
- The output register is free when !inst_valid or the packet is being consumed this cycle.
- Redirect target: tgt = flush_pc if flush_valid, else redirect_pc.
  - redir = flush_valid | redirect_valid.
- Sequential next PC: next_pc = {pc[31:3]+1, 3'b000}. It wraps modulo 2^32.
- Slot mask from pc[2]:
  - pc[2] = 0 → mask 2'b11.
  - pc[2] = 1 → mask 2'b10.
- States:
  - IDLE:
    - Single cycle after reset deasserts.
    - imem_req = 0. Go to REQ unconditionally.
    - If redir is high, pc <= tgt.
  - REQ:
    - imem_req = output-free && !redir; imem_addr = aligned pc.
    - If redir: pc <= tgt, clear inst_valid, stay in REQ, no request this cycle.
    - Else if imem_req && imem_gnt: go to WAIT.
    - Before grant, imem_req is not withdrawn except on redir or a non-free output.
  - WAIT:
    - imem_req = 0.
    - If redir with no imem_rvalid: pc <= tgt, clear inst_valid, go to KILL.
    - If redir with imem_rvalid in the same cycle: drop the response, pc <= tgt, clear inst_valid, go to REQ.
    - Else on imem_rvalid: load inst_valid = 1, inst_pc = pc, inst_mask, inst_data = imem_rdata; then pc <= next_pc and go to REQ. The output is guaranteed free by the REQ gating.
  - KILL:
    - imem_req = 0. inst_valid stays 0.
    - On imem_rvalid: discard the response and go to REQ.
    - A redir in KILL updates pc <= tgt and stays in KILL, or goes to REQ if imem_rvalid is also high.
- Flush and redirect in the same cycle: flush wins, redirect_pc is ignored.
- A redirect always clears inst_valid in that cycle's update, even if stall is high.
- With stall held, inst_* hold their values and no new request is issued while the output register is occupied.
- Throughput: at most one packet per 2 cycles with 1-cycle memory latency and gnt in the request cycle.
- Exactly one outstanding request at any time. A response in IDLE/REQ is a protocol error; the block ignores it.

Test Plan:
- Reset release, RESET_PC = 0, gnt tied to 1, rvalid 1 cycle after gnt, stall = 0 → addresses 0x0, 0x8, 0x10; packets with inst_pc 0x0/0x8/0x10, mask 2'b11.
- In WAIT, redirect_valid with redirect_pc = 0x104, rvalid 2 cycles later → response dropped, no inst_valid for it. Next imem_addr = 0x100; resulting packet has inst_pc 0x104, mask 2'b10.
- flush_valid (flush_pc = 0x80) and redirect_valid (0x200) in the same cycle → next imem_addr = 0x80.
- stall held 5 cycles with a packet valid → inst_* stable, imem_req = 0 throughout. On stall release the next request is issued in the same cycle the packet is consumed.
- imem_gnt held low 3 cycles in REQ → imem_req and imem_addr held steady. A redirect during the wait moves imem_addr to the target in the next cycle.
- reset asserted while in WAIT → all outputs 0 immediately without a clock edge; after release imem_addr = RESET_PC.
- pc = 0xFFFF_FFF8 sequential → next imem_addr = 0x0000_0000 (wrap).
